// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding, done-cause codes and default widths
// for the core run controller.
package run_ctrl_pkg;
   typedef enum logic [1:0] {HOLD, IDLE, RUN, HALTED} run_state_t;
   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_LIMIT = 2'b01;
   localparam logic [1:0] CAUSE_HALT  = 2'b10;
   localparam logic [1:0] CAUSE_BOTH  = 2'b11;
   localparam int CNT_W_DEF = 32;
   localparam int HOLD_W    = 8;
endpackage

// File: rtl/reset_sync.sv
// reset_sync: 2-flop synchroniser, asserts asynchronously with reset low,
// deasserts on the second rising edge after release.
module reset_sync (
   input  logic clk,
   input  logic reset,
   output logic rst_s
);
   logic meta;
   always_ff @(posedge clk or negedge reset)
      if (!reset) {rst_s, meta} <= 2'b00;
      else {rst_s, meta} <= {meta, 1'b1};
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: stretched core reset, clock-enabled run window, cycle limit / halt stop.
// Define RUN_CTRL_STEP_EN to add single-step ports step_mode and step_req.
module cpu_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RST_HOLD   = 4,
   parameter int MAX_CYCLES = 100,
   parameter bit AUTO_START = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_req,
`ifdef RUN_CTRL_STEP_EN
   input  logic             step_mode,
   input  logic             step_req,
`endif
   output logic             core_reset,
   output logic             core_en,
   output logic             running,
   output logic             done,
   output logic [1:0]       done_cause,
   output logic [CNT_W-1:0] cycle_count
);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0]  LIMIT_LAST = CNT_W'(MAX_CYCLES - 1);
   run_state_t state, state_d;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic [CNT_W-1:0] count_d;
   logic [1:0] cause_d;
   logic rst_s, core_reset_d, step_go, limit_hit;
   reset_sync u_sync (.clk(clk), .reset(reset), .rst_s(rst_s));
`ifdef RUN_CTRL_STEP_EN
   logic step_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) step_q <= 1'b0;
      else step_q <= step_req;
   assign step_go = !step_mode || (step_req && !step_q);
`else
   assign step_go = 1'b1;
`endif
   assign limit_hit = (MAX_CYCLES != 0) && (cycle_count == LIMIT_LAST);
   always_comb begin
      state_d = state;
      hold_d = hold_cnt;
      core_reset_d = core_reset;
      count_d = cycle_count;
      cause_d = done_cause;
      case (state)
         HOLD: if (rst_s) begin
            hold_d = hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               core_reset_d = 1'b1;
               state_d = AUTO_START ? RUN : IDLE;
            end
         end
         IDLE: if (start) state_d = RUN;
         // only enabled cycles count and may stop the core
         RUN: if (core_en) begin
            count_d = &cycle_count ? cycle_count : cycle_count + 1'b1;
            if (limit_hit || halt_req) begin
               state_d = HALTED;
               cause_d = (limit_hit && halt_req) ? CAUSE_BOTH : halt_req ? CAUSE_HALT : CAUSE_LIMIT;
            end
         end
         HALTED: if (start) begin
            state_d = HOLD;
            hold_d = '0;
            core_reset_d = 1'b0;
            count_d = '0;
            cause_d = CAUSE_NONE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= HOLD;
         hold_cnt <= '0;
         core_reset <= 1'b0;
         core_en <= 1'b0;
         running <= 1'b0;
         done <= 1'b0;
         done_cause <= CAUSE_NONE;
         cycle_count <= '0;
      end else begin
         state <= state_d;
         hold_cnt <= hold_d;
         core_reset <= core_reset_d;
         core_en <= (state_d == RUN) && step_go;
         running <= state_d == RUN;
         done <= state_d == HALTED;
         done_cause <= cause_d;
         cycle_count <= count_d;
      end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed stimulus on an auto-start and a start-gated instance;
// done results are scored from per-instance expectation queues.
module tb_cpu_run_ctrl;
   import run_ctrl_pkg::*;
   logic clk = 1'b0;
   logic reset_a = 1'b1, reset_b = 1'b1, start_a = 1'b0, start_b = 1'b0, halt_a = 1'b0;
   logic core_reset_a, core_en_a, running_a, done_a;
   logic core_reset_b, core_en_b, running_b, done_b;
   logic [1:0] cause_a, cause_b;
   logic [31:0] count_a, count_b;
   int checks = 0, failures = 0;
   logic [33:0] q_a[$], q_b[$];
   logic prev_a = 1'b0, prev_b = 1'b0;
`ifdef RUN_CTRL_STEP_EN
   logic step_mode = 1'b0, step_req = 1'b0;
`endif
   always #5 clk = ~clk;
   cpu_run_ctrl #(.CNT_W(32), .RST_HOLD(4), .MAX_CYCLES(100), .AUTO_START(1'b1)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .halt_req(halt_a),
`ifdef RUN_CTRL_STEP_EN
      .step_mode(step_mode), .step_req(step_req),
`endif
      .core_reset(core_reset_a), .core_en(core_en_a), .running(running_a), .done(done_a),
      .done_cause(cause_a), .cycle_count(count_a));
   cpu_run_ctrl #(.CNT_W(32), .RST_HOLD(4), .MAX_CYCLES(5), .AUTO_START(1'b0)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .halt_req(1'b0),
`ifdef RUN_CTRL_STEP_EN
      .step_mode(1'b0), .step_req(1'b0),
`endif
      .core_reset(core_reset_b), .core_en(core_en_b), .running(running_b), .done(done_b),
      .done_cause(cause_b), .cycle_count(count_b));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (done_a && !prev_a) begin
         chk("a_result_pending", q_a.size() != 0, 1);
         if (q_a.size() != 0) chk("a_done_result", {cause_a, count_a}, q_a.pop_front());
      end
      if (done_b && !prev_b) begin
         chk("b_result_pending", q_b.size() != 0, 1);
         if (q_b.size() != 0) chk("b_done_result", {cause_b, count_b}, q_b.pop_front());
      end
      prev_a = done_a;
      prev_b = done_b;
   end
   task automatic wait_core_reset_a(input int exp_edge);
      int k = 0;
      while (!core_reset_a && k < 20) begin
         tick();
         k++;
      end
      chk("a_core_reset_edge", k, exp_edge);
   endtask
   task automatic run_until_done_a(input int exp_en);
      int n = 0;
      for (int i = 0; i < 400 && !done_a; i++) begin
         if (core_en_a) n++;
         tick();
      end
      chk("a_done", done_a, 1);
      chk("a_en_cycles", n, exp_en);
   endtask
   task automatic restart_a();
      int n = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("a_restart_count", count_a, 0);
      chk("a_restart_done", {done_a, cause_a}, 0);
      for (int i = 0; i < 20 && !core_reset_a; i++) begin
         n++;
         tick();
      end
      chk("a_restart_hold_cycles", n, 4);
   endtask
   initial begin
      int n;
      #2;
      reset_a = 1'b0;
      reset_b = 1'b0;
      repeat (2) tick();
      chk("a_reset_state", {core_reset_a, core_en_a, running_a, done_a, cause_a, count_a}, 0);
      chk("b_reset_state", {core_reset_b, core_en_b, running_b, done_b, cause_b, count_b}, 0);
      reset_a = 1'b1;
      wait_core_reset_a(6);
      chk("a_run_entry", {running_a, core_en_a}, 2'b11);
      q_a.push_back({CAUSE_LIMIT, 32'd100});
      run_until_done_a(100);
      chk("a_limit_en_low", {core_en_a, running_a}, 0);
      restart_a();
      chk("a_autostart_en", core_en_a, 1);
      q_a.push_back({CAUSE_HALT, 32'd37});
      repeat (36) tick();
      chk("a_count_at_37th", count_a, 36);
      halt_a = 1'b1;
      tick();
      halt_a = 1'b0;
      chk("a_halt_en_low", core_en_a, 0);
      chk("a_halt_done", done_a, 1);
      restart_a();
      q_a.push_back({CAUSE_BOTH, 32'd100});
      repeat (99) tick();
      halt_a = 1'b1;
      tick();
      halt_a = 1'b0;
      chk("a_both_done", done_a, 1);
      halt_a = 1'b1;
      repeat (3) tick();
      halt_a = 1'b0;
      chk("a_halted_holds", {done_a, cause_a, count_a}, {1'b1, CAUSE_BOTH, 32'd100});
      restart_a();
      repeat (49) tick();
      chk("a_count_at_50th", count_a, 49);
      #2 reset_a = 1'b0;
      #1;
      chk("a_async_reset", {core_reset_a, core_en_a, running_a, done_a, cause_a, count_a}, 0);
      tick();
      reset_a = 1'b1;
      q_a.push_back({CAUSE_LIMIT, 32'd100});
      wait_core_reset_a(6);
      run_until_done_a(100);
`ifdef RUN_CTRL_STEP_EN
      step_mode = 1'b1;
      restart_a();
      chk("a_step_idle", {running_a, core_en_a}, 2'b10);
      n = 0;
      for (int p = 0; p < 3; p++) begin
         step_req = 1'b1;
         tick();
         if (core_en_a) n++;
         step_req = 1'b0;
         repeat (4) begin
            tick();
            if (core_en_a) n++;
         end
      end
      chk("a_step_pulses", n, 3);
      chk("a_step_count", count_a, 3);
      step_mode = 1'b0;
      q_a.push_back({CAUSE_LIMIT, 32'd100});
      run_until_done_a(97);
`endif
      tick();
      reset_b = 1'b1;
      n = 0;
      while (!core_reset_b && n < 20) begin
         tick();
         n++;
      end
      chk("b_core_reset_edge", n, 6);
      n = 0;
      repeat (20) begin
         tick();
         if (core_en_b) n++;
      end
      chk("b_idle_en_cycles", n, 0);
      chk("b_idle_running", running_b, 0);
      q_b.push_back({CAUSE_LIMIT, 32'd5});
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_start_run", {running_b, core_en_b}, 2'b11);
      n = 0;
      for (int i = 0; i < 50 && !done_b; i++) begin
         if (core_en_b) n++;
         tick();
      end
      chk("b_en_cycles", n, 5);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_restart_count", {core_reset_b, count_b}, 0);
      n = 0;
      for (int i = 0; i < 20 && !core_reset_b; i++) begin
         n++;
         tick();
      end
      chk("b_restart_hold_cycles", n, 4);
      repeat (2) tick();
      chk("b_back_to_idle", {running_b, core_en_b}, 0);
      tick();
      chk("a_queue_drained", q_a.size(), 0);
      chk("b_queue_drained", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller for the single-cycle MIPS core; it replaces the fixed-length reset-pulse and 100-toggle run window.
- Sequences a clean, stretched core reset after system reset.
- Gates the core with a clock enable and counts executed cycles.
- Stops the core on a cycle limit or an external halt request, and reports the cause.
- Sits between the top-level clock/reset pins and `main`; the core sees only `core_reset` and `core_en`.

Parameters:
- CNT_W, 32, width of cycle_count.
- RST_HOLD, 4, cycles core_reset stays low after synchronised reset release (1..255).
- MAX_CYCLES, 100, enabled cycles before auto-halt; 0 = unlimited.
- AUTO_START, 1, 1 = enter RUN directly after HOLD; 0 = wait in IDLE for start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low system reset.
- start  in  1  pulse; launches run from IDLE, restarts from HALTED.
- halt_req  in  1  level; core requests stop (e.g. halt opcode decoded).
- core_reset  out  1  active-low reset to core; asserts async with reset, deasserts sync.
- core_en  out  1  core clock enable / PC-update enable.
- running  out  1  high in RUN.
- done  out  1  high in HALTED, sticky.
- done_cause  out  2  01 limit, 10 halt_req, 11 both in same cycle, 00 not done.
- cycle_count  out  CNT_W  enabled cycles executed since last core reset.

Behaviour:
- reset low (async): state=HOLD; hold_cnt=0; core_reset=0; core_en=0; running=0; done=0; done_cause=00; cycle_count=0.
- reset release passes a 2-flop synchroniser. Internal rst_s goes high on the 2nd rising edge after release.
- Reset mid-operation: every output returns to its reset value immediately. No partial state survives.

State machine:
- HOLD
  - hold_cnt increments each cycle while rst_s=1.
  - When hold_cnt==RST_HOLD-1: core_reset<=1, then go to RUN if AUTO_START=1, else IDLE.
  - Total: core_reset rises at edge RST_HOLD+2 after release.
- IDLE
  - core_en=0.
  - start=1 -> RUN on the next edge.
- RUN
  - core_en=1, running=1, start ignored.
  - Each RUN cycle: cycle_count+1. The count saturates at all-ones; the core stays in RUN.
  - limit_hit = (MAX_CYCLES!=0) && (cycle_count==MAX_CYCLES-1). Exactly MAX_CYCLES enabled cycles execute.
  - halt_req=1 sampled in RUN: the current cycle still counts; leave on the next edge.
  - limit_hit or halt_req -> HALTED. done_cause as encoded under Ports.
- HALTED
  - core_en=0, done=1. cycle_count and done_cause hold.
  - halt_req ignored.
  - start=1: clear done, done_cause and cycle_count; core_reset<=0; hold_cnt=0; go to HOLD (full re-reset of core, no synchroniser delay).
- All outputs are registered. core_en never glitches and is 0 whenever core_reset=0.

Optional Feature:
- Macro: RUN_CTRL_STEP_EN.
- When defined:
  - Adds ports step_mode (in, 1) and step_req (in, 1).
  - In RUN with step_mode=1, core_en is high for exactly one cycle per rising edge of step_req (registered edge detect). Otherwise it is 0.
  - cycle_count, the limit and halt_req apply only on enabled cycles.
  - step_mode is sampled each cycle; clearing it resumes free run on the next edge.
- When undefined: ports are absent and behaviour equals step_mode=0.

Decomposition:
- Package run_ctrl_pkg:
  - State enum (HOLD, IDLE, RUN, HALTED).
  - done_cause constants CAUSE_NONE / LIMIT / HALT / BOTH.
  - Default widths.
- One sub-module: reset_sync (2-flop async-assert, sync-deassert synchroniser), reused by other blocks.

Test Plan:
- MAX_CYCLES=100, RST_HOLD=4, AUTO_START=1; release reset, never raise halt_req.
  - core_reset rises at edge 6.
  - core_en is high for exactly 100 cycles.
  - Then done=1, done_cause=01, cycle_count=100.
- halt_req pulsed for 1 cycle at the 37th enabled cycle -> done_cause=10, cycle_count=37, core_en low on the next cycle.
- halt_req asserted on the same cycle as the 100th enabled cycle -> done_cause=11, cycle_count=100.
- Reset dropped low mid-RUN at cycle 50 -> core_reset=0 and core_en=0 within the same delta, cycle_count=0; on release the full sequence replays.
- AUTO_START=0: stays IDLE with core_en=0 for 20 cycles; start pulse -> RUN next edge. start pulse in HALTED -> core_reset low for 4 cycles, count restarts from 0.
- RUN_CTRL_STEP_EN, step_mode=1: 3 step_req pulses 5 cycles apart -> exactly 3 single-cycle core_en pulses, cycle_count=3.
